ladybird_bus_arbiter: RTL and testbench

Shares the single core bus (BUS_DATA_W-wide line transfers) between the L1 instruction cache (requester BUS_ID_I) and the L1 data cache (requester BUS_ID_D).
- Grants one requester at a time with round-robin priority.
- Registers the granted request and drives it onto the downstream bus.
- Routes the single response back to the owner.
- Exactly one transaction is outstanding at any time.
- Sits between the L1 caches and the platform interconnect.

---
 rtl/ladybird_config_pkg.sv | 17 +
 rtl/ladybird_rr_arbiter.sv | 36 +++
 rtl/ladybird_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_ladybird_bus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ladybird_config_pkg.sv
// rtl/ladybird_config_pkg.sv - shared bus widths, requester IDs and arbiter state type
package ladybird_config;

    localparam int BUS_DATA_W  = 128;
    localparam int BUS_ADDR_W  = 32;
    localparam int BUS_ID_I    = 0;
    localparam int BUS_ID_D    = 1;
    localparam int BUS_NUM_REQ = 2;
    localparam int BUS_STRB_W  = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } bus_arb_state_t;

endpackage

// File: rtl/ladybird_rr_arbiter.sv
// rtl/ladybird_rr_arbiter.sv - combinational round-robin pick of the first valid requester after the last grant
module ladybird_rr_arbiter
    import ladybird_config::*;
#(
    parameter int NUM_REQ = BUS_NUM_REQ,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_grant_any
);

    int              cand;
    logic [ID_W-1:0] cand_idx;

    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand     = (int'(i_last) + k) % NUM_REQ;
            cand_idx = ID_W'(cand);
            if (i_valid[cand_idx]) begin
                o_grant_oh  = NUM_REQ'(1) << cand_idx;
                o_grant_idx = cand_idx;
                o_grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ladybird_bus_arbiter.sv
// rtl/ladybird_bus_arbiter.sv - shares the core line bus between I and D caches, one transaction at a time
module ladybird_bus_arbiter
    import ladybird_config::*;
#(
    parameter int NUM_REQ = BUS_NUM_REQ,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int STRB_W  = DATA_W / 8,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]        i_req_we,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0] i_req_wstrb,
    output logic [NUM_REQ-1:0]        o_resp_valid,
    input  logic [NUM_REQ-1:0]        i_resp_ready,
    output logic [DATA_W-1:0]         o_resp_data,
    output logic                      o_bus_valid,
    input  logic                      i_bus_ready,
    output logic [ADDR_W-1:0]         o_bus_addr,
    output logic                      o_bus_we,
    output logic [DATA_W-1:0]         o_bus_wdata,
    output logic [STRB_W-1:0]         o_bus_wstrb,
    output logic [ID_W-1:0]           o_bus_id,
    input  logic                      i_bus_resp_valid,
    output logic                      o_bus_resp_ready,
    input  logic [DATA_W-1:0]         i_bus_resp_data,
    output logic                      o_busy
);

    bus_arb_state_t    state_q, state_d;
    logic              bus_valid_q, bus_valid_d;
    logic [ID_W-1:0]   bus_id_q, bus_id_d;
    logic [ID_W-1:0]   rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;

    ladybird_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_valid     (i_req_valid),
        .i_last      (rr_last_q),
        .o_grant_oh  (grant_oh),
        .o_grant_idx (grant_idx),
        .o_grant_any (grant_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            bus_valid_q <= 1'b0;
            bus_id_q    <= '0;
            rr_last_q   <= ID_W'(BUS_ID_D);
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_id_q    <= bus_id_d;
            rr_last_q   <= rr_last_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    // In IDLE the granted requester always sees ready, so a grant is a handshake.
    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_id_d    = bus_id_q;
        rr_last_d   = rr_last_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_any) begin
                    state_d     = ARB_REQ;
                    bus_valid_d = 1'b1;
                    bus_id_d    = grant_idx;
                    rr_last_d   = grant_idx;
                    for (int r = 0; r < NUM_REQ; r++) begin
                        if (grant_idx == ID_W'(r)) begin
                            addr_d  = i_req_addr[r*ADDR_W +: ADDR_W];
                            we_d    = i_req_we[r];
                            wdata_d = i_req_wdata[r*DATA_W +: DATA_W];
                            wstrb_d = i_req_wstrb[r*STRB_W +: STRB_W];
                        end
                    end
                end
            end
            ARB_REQ: begin
                if (i_bus_ready) begin
                    state_d     = ARB_RESP;
                    bus_valid_d = 1'b0;
                end
            end
            ARB_RESP: begin
                if (i_bus_resp_valid && i_resp_ready[bus_id_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready      = (state_q == ARB_IDLE) ? grant_oh : '0;
        o_resp_valid     = '0;
        o_bus_resp_ready = 1'b0;
        if (state_q == ARB_RESP) begin
            o_resp_valid[bus_id_q] = i_bus_resp_valid;
            o_bus_resp_ready       = i_resp_ready[bus_id_q];
        end
        o_resp_data = i_bus_resp_data;
        o_bus_valid = bus_valid_q;
        o_bus_addr  = addr_q;
        o_bus_we    = we_q;
        o_bus_wdata = wdata_q;
        o_bus_wstrb = wstrb_q;
        o_bus_id    = bus_id_q;
        o_busy      = (state_q != ARB_IDLE);
    end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// tb/tb_ladybird_bus_arbiter.sv - directed and randomized checks of the bus arbiter against a transaction model
module tb_ladybird_bus_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   i_req_valid, o_req_ready;
    logic [63:0]  i_req_addr;
    logic [1:0]   i_req_we;
    logic [255:0] i_req_wdata;
    logic [31:0]  i_req_wstrb;
    logic [1:0]   o_resp_valid, i_resp_ready;
    logic [127:0] o_resp_data;
    logic         o_bus_valid, i_bus_ready;
    logic [31:0]  o_bus_addr;
    logic         o_bus_we;
    logic [127:0] o_bus_wdata;
    logic [15:0]  o_bus_wstrb;
    logic         o_bus_id;
    logic         i_bus_resp_valid, o_bus_resp_ready;
    logic [127:0] i_bus_resp_data;
    logic         o_busy;

    logic [1:0]   vld;
    logic [31:0]  a [2];
    logic [1:0]   we;
    logic [127:0] wd [2];
    logic [15:0]  ws [2];

    assign i_req_valid = vld;
    assign i_req_addr  = {a[1], a[0]};
    assign i_req_we    = we;
    assign i_req_wdata = {wd[1], wd[0]};
    assign i_req_wstrb = {ws[1], ws[0]};

    ladybird_bus_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_addr       (i_req_addr),
        .i_req_we         (i_req_we),
        .i_req_wdata      (i_req_wdata),
        .i_req_wstrb      (i_req_wstrb),
        .o_resp_valid     (o_resp_valid),
        .i_resp_ready     (i_resp_ready),
        .o_resp_data      (o_resp_data),
        .o_bus_valid      (o_bus_valid),
        .i_bus_ready      (i_bus_ready),
        .o_bus_addr       (o_bus_addr),
        .o_bus_we         (o_bus_we),
        .o_bus_wdata      (o_bus_wdata),
        .o_bus_wstrb      (o_bus_wstrb),
        .o_bus_id         (o_bus_id),
        .i_bus_resp_valid (i_bus_resp_valid),
        .o_bus_resp_ready (o_bus_resp_ready),
        .i_bus_resp_data  (i_bus_resp_data),
        .o_busy           (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction model: phase 0 = waiting for a grant, 1 = request offered, 2 = awaiting response.
    int           m_known = 0;
    int           m_phase, m_last, m_owner, m_grant;
    logic [31:0]  m_addr;
    logic         m_we;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic [1:0]   accepted;
    int           cyc = 0;
    int           grant_log[$];
    int           acc_cyc[$];
    logic [31:0]  lit_addr;
    logic [127:0] lit_wdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_check();
        int         c0;
        logic [1:0] exp_rr;
        logic [1:0] exp_rv;
        m_grant = -1;
        if (m_phase == 0) begin
            c0 = (m_last + 1) % 2;
            if (vld[c0[0]]) m_grant = c0;
            else if (vld[m_last[0]]) m_grant = m_last;
        end
        if (m_known == 0) return;
        exp_rr = 2'b00;
        if (m_grant >= 0) exp_rr[m_grant[0]] = 1'b1;
        exp_rv = 2'b00;
        if (m_phase == 2 && i_bus_resp_valid) exp_rv[m_owner[0]] = 1'b1;
        chk("m_req_ready", o_req_ready, exp_rr);
        chk("m_bus_valid", o_bus_valid, m_phase == 1);
        chk("m_busy", o_busy, m_phase != 0);
        chk("m_resp_valid", o_resp_valid, exp_rv);
        chk("m_bus_resp_ready", o_bus_resp_ready, m_phase == 2 && i_resp_ready[m_owner[0]]);
        if (m_phase != 0) chk("m_bus_id", o_bus_id, m_owner[0]);
        if (m_phase == 1) begin
            chk("m_bus_addr", o_bus_addr, m_addr);
            chk("m_bus_we", o_bus_we, m_we);
            chk("m_bus_wdata", o_bus_wdata, m_wdata);
            chk("m_bus_wstrb", o_bus_wstrb, m_wstrb);
        end
        if (exp_rv != 2'b00) chk("m_resp_data", o_resp_data, i_bus_resp_data);
    endtask

    task automatic model_step();
        accepted = 2'b00;
        if (rst) begin
            m_known = 1;
            m_phase = 0;
            m_last  = 1;
            m_owner = 0;
        end else if (m_phase == 0) begin
            if (m_grant >= 0) begin
                m_phase = 1;
                m_owner = m_grant;
                m_last  = m_grant;
                m_addr  = a[m_grant[0]];
                m_we    = we[m_grant[0]];
                m_wdata = wd[m_grant[0]];
                m_wstrb = ws[m_grant[0]];
                accepted[m_grant[0]] = 1'b1;
                grant_log.push_back(m_grant);
                acc_cyc.push_back(cyc);
            end
        end else if (m_phase == 1) begin
            if (i_bus_ready) m_phase = 2;
        end else begin
            if (i_bus_resp_valid && i_resp_ready[m_owner[0]]) m_phase = 0;
        end
    endtask

    task automatic cycle();
        #2;
        model_check();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < 2; r++) if (accepted[r]) vld[r] = 1'b0;
    endtask

    task automatic new_req(input int r);
        logic [31:0] t;
        t     = $urandom;
        a[r]  = {t[31:4], 4'h0};
        we[r] = t[0];
        wd[r] = {$urandom, $urandom, $urandom, $urandom};
        t     = $urandom;
        ws[r] = t[15:0];
        vld[r] = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        vld = 2'b00;
        we  = 2'b00;
        for (int r = 0; r < 2; r++) begin
            a[r] = '0; wd[r] = '0; ws[r] = '0;
        end
        i_resp_ready     = 2'b11;
        i_bus_ready      = 1'b0;
        i_bus_resp_valid = 1'b0;
        i_bus_resp_data  = 128'h0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_bus_valid", o_bus_valid, 1'b0);
        chk("rst_bus_id", o_bus_id, 1'b0);
        chk("rst_bus_addr", o_bus_addr, 32'h0);

        // Simultaneous I read and D write straight after reset: I wins the tie.
        a[0] = 32'h8000_0000; we[0] = 1'b0; wd[0] = '0; ws[0] = 16'h0;
        a[1] = 32'h8000_0040; we[1] = 1'b1; wd[1] = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        ws[1] = 16'hFFFF;
        vld = 2'b11;
        i_bus_ready = 1'b1;
        #1;
        chk("t1_ready_i", o_req_ready, 2'b01);
        cycle();
        #1;
        chk("t1_bus_valid", o_bus_valid, 1'b1);
        chk("t1_bus_id", o_bus_id, 1'b0);
        chk("t1_bus_addr", o_bus_addr, 32'h8000_0000);
        chk("t1_ready_off", o_req_ready, 2'b00);
        cycle();
        i_bus_resp_valid = 1'b1;
        i_bus_resp_data  = 128'hDEAD_BEEF;
        #1;
        chk("t1_resp_i", o_resp_valid, 2'b01);
        cycle();
        i_bus_resp_valid = 1'b0;
        #1;
        chk("t1_ready_d", o_req_ready, 2'b10);
        cycle();
        #1;
        chk("t1_bus_id_d", o_bus_id, 1'b1);
        chk("t1_bus_wstrb", o_bus_wstrb, 16'hFFFF);
        chk("t1_bus_addr_d", o_bus_addr, 32'h8000_0040);
        cycle();
        i_bus_resp_valid = 1'b1;
        cycle();
        i_bus_resp_valid = 1'b0;

        // Both requesters continuously valid: grants must alternate.
        grant_log.delete();
        i_bus_resp_valid = 1'b1;
        for (int n = 0; n < 40 && grant_log.size() < 6; n++) begin
            if (!vld[0]) new_req(0);
            if (!vld[1]) new_req(1);
            i_bus_resp_data = {4{$urandom}};
            cycle();
        end
        vld = 2'b00;
        chk("t3_grant_count", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            chk($sformatf("t3_grant%0d", k), grant_log[k], k % 2);
        for (int n = 0; n < 6; n++) cycle();

        // D alone, back-to-back with zero downstream wait.
        grant_log.delete();
        acc_cyc.delete();
        for (int n = 0; n < 30 && grant_log.size() < 4; n++) begin
            if (!vld[1]) begin
                new_req(1);
                we[1] = 1'b0;
            end
            i_bus_resp_data = {4{$urandom}};
            cycle();
        end
        vld = 2'b00;
        chk("t2_grant_count", grant_log.size(), 4);
        for (int k = 0; k < grant_log.size(); k++) chk($sformatf("t2_grant%0d", k), grant_log[k], 1);
        for (int k = 1; k < acc_cyc.size(); k++)
            chk($sformatf("t2_spacing%0d", k), acc_cyc[k] - acc_cyc[k-1], 3);
        for (int n = 0; n < 4; n++) cycle();

        // Downstream stall in REQ with a stray response, then owner back-pressure in RESP.
        i_bus_ready      = 1'b0;
        i_bus_resp_valid = 1'b1;
        new_req(0);
        a[0] = 32'h1234_5680; we[0] = 1'b1; ws[0] = 16'h00F0;
        lit_wdata = wd[0];
        cycle();
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("t4_bus_valid", o_bus_valid, 1'b1);
            chk("t4_bus_addr", o_bus_addr, 32'h1234_5680);
            chk("t4_bus_wdata", o_bus_wdata, lit_wdata);
            chk("t4_no_resp", o_resp_valid, 2'b00);
            cycle();
        end
        i_bus_ready = 1'b1;
        cycle();
        i_resp_ready = 2'b10;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("t5_bus_resp_ready", o_bus_resp_ready, 1'b0);
            chk("t5_resp_valid", o_resp_valid, 2'b01);
            chk("t5_busy", o_busy, 1'b1);
            cycle();
        end
        i_resp_ready = 2'b11;
        #1;
        chk("t5_bus_resp_ready_hi", o_bus_resp_ready, 1'b1);
        cycle();
        #1;
        chk("t5_idle", o_busy, 1'b0);

        // Reset while the response is pending.
        i_resp_ready = 2'b00;
        new_req(0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("t6_busy", o_busy, 1'b0);
        chk("t6_bus_valid", o_bus_valid, 1'b0);
        chk("t6_resp_valid", o_resp_valid, 2'b00);
        i_resp_ready = 2'b11;
        if (!vld[0]) new_req(0);
        if (!vld[1]) new_req(1);
        #1;
        chk("t6_ready_i", o_req_ready, 2'b01);
        cycle();

        // Randomized traffic, including stray responses and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < 2; r++) if (!vld[r] && $urandom_range(0, 99) < 50) new_req(r);
            rst              = ($urandom_range(0, 499) == 0);
            i_bus_ready      = ($urandom_range(0, 2) != 0);
            i_bus_resp_valid = $urandom_range(0, 1) != 0;
            i_resp_ready     = 2'($urandom_range(0, 3));
            i_bus_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
